piano_keypad: RTL and testbench



---
 rtl/piano_keypad_if.sv | 29 ++
 rtl/piano_keypad.sv | 74 +++++++
 tb/tb_piano_keypad.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/piano_keypad_if.sv
// ============================================================================
// Module  : piano_keypad_if
// Brief   : Scanner-to-tone-generator keypad bus (key input, note/octave out).
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface piano_keypad_if;
  logic       ready;
  logic [4:0] keycode;
  logic [3:0] note;
  logic [3:0] octave;

  modport master (
    output ready,
    output keycode,
    input  note,
    input  octave
  );

  modport slave (
    input  ready,
    input  keycode,
    output note,
    output octave
  );
endinterface

`default_nettype wire

// File: rtl/piano_keypad.sv
// ============================================================================
// Module  : piano_keypad
// Brief   : Keycode to registered note/octave, with one-shot octave keys.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module piano_keypad #(
  parameter int DEFAULT_OCTAVE = 4,
  parameter int MIN_OCTAVE     = 0,
  parameter int MAX_OCTAVE     = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  piano_keypad_if.slave  kp
);

  localparam logic [3:0] c_oct_default = 4'(DEFAULT_OCTAVE);
  localparam logic [3:0] c_oct_min     = 4'(MIN_OCTAVE);
  localparam logic [3:0] c_oct_max     = 4'(MAX_OCTAVE);
  localparam logic [4:0] c_key_notes   = 5'd12;
  localparam logic [4:0] c_key_down    = 5'd12;
  localparam logic [4:0] c_key_up      = 5'd13;
  localparam logic [4:0] c_key_reset   = 5'd14;

  logic       r_prev_ready;
  logic [4:0] r_prev_keycode;
  logic [3:0] r_note;
  logic [3:0] r_octave;

  logic       w_press;
  logic [3:0] w_note_next;
  logic [3:0] w_octave_next;

  // A press is a fresh ready or a keycode change while held (legato switch).
  always_comb begin
    w_press = kp.ready && (!r_prev_ready || (kp.keycode != r_prev_keycode));

    w_note_next = 4'd0;
    if (kp.ready && (kp.keycode < c_key_notes)) begin
      w_note_next = kp.keycode[3:0] + 4'd1;
    end

    w_octave_next = r_octave;
    if (w_press) begin
      case (kp.keycode)
        c_key_down:  if (r_octave > c_oct_min) w_octave_next = r_octave - 4'd1;
        c_key_up:    if (r_octave < c_oct_max) w_octave_next = r_octave + 4'd1;
        c_key_reset: w_octave_next = c_oct_default;
        default:     w_octave_next = r_octave;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_ready   <= 1'b0;
      r_prev_keycode <= 5'd0;
      r_note         <= 4'd0;
      r_octave       <= c_oct_default;
    end else begin
      r_prev_ready   <= kp.ready;
      r_prev_keycode <= kp.keycode;
      r_note         <= w_note_next;
      r_octave       <= w_octave_next;
    end
  end

  assign kp.note   = r_note;
  assign kp.octave = r_octave;

endmodule

`default_nettype wire

// File: tb/tb_piano_keypad.sv
// ============================================================================
// Module  : tb_piano_keypad
// Brief   : Directed scoreboard bench for piano_keypad.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_piano_keypad;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  piano_keypad_if kp ();

  piano_keypad #(
    .DEFAULT_OCTAVE (4),
    .MIN_OCTAVE     (0),
    .MAX_OCTAVE     (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] note;
    logic [3:0] octave;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic compare_head();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (kp.note === e.note) else begin
      fails++;
      $error("FAIL %s note: observed %0d expected %0d", e.tag, kp.note, e.note);
    end
    checks++;
    assert (kp.octave === e.octave) else begin
      fails++;
      $error("FAIL %s octave: observed %0d expected %0d", e.tag, kp.octave, e.octave);
    end
  endtask

  // Drive one cycle of scanner input, expect the registered result after the edge.
  task automatic step(input logic r, input logic [4:0] k,
                      input int en, input int eo, input string tag);
    exp_t e;
    kp.ready   = r;
    kp.keycode = k;
    e.note   = 4'(en);
    e.octave = 4'(eo);
    e.tag    = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  // Check outputs right now, with no clock edge in between.
  task automatic check_now(input int en, input int eo, input string tag);
    exp_t e;
    e.note   = 4'(en);
    e.octave = 4'(eo);
    e.tag    = tag;
    sb.push_back(e);
    compare_head();
  endtask

  initial begin
    kp.ready   = 1'b0;
    kp.keycode = 5'd0;

    // Reset state
    #12;
    check_now(0, 4, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: note F held
    step(1'b1, 5'd5, 6, 4, "t1_first");
    for (int i = 0; i < 10; i++) step(1'b1, 5'd5, 6, 4, "t1_hold");

    // 2: release
    step(1'b0, 5'd5, 0, 4, "t2_release");

    // 3: three octave-up presses, then a long hold
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd13, 0, 5 + i, "t3_up");
      step(1'b0, 5'd13, 0, 5 + i, "t3_gap");
    end
    step(1'b1, 5'd13, 0, 8, "t3_hold_first");
    for (int i = 0; i < 19; i++) step(1'b1, 5'd13, 0, 8, "t3_hold");
    step(1'b0, 5'd0, 0, 8, "t3_rel");

    // 4: saturation at both ends, then octave reset key
    step(1'b1, 5'd13, 0, 8, "t4_sat_hi");
    step(1'b0, 5'd13, 0, 8, "t4_gap");
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 5'd12, 0, 7 - i, "t4_down");
      step(1'b0, 5'd12, 0, 7 - i, "t4_gap");
    end
    step(1'b1, 5'd12, 0, 0, "t4_sat_lo");
    step(1'b0, 5'd12, 0, 0, "t4_gap");
    step(1'b1, 5'd14, 0, 4, "t4_oct_reset");
    step(1'b1, 5'd14, 0, 4, "t4_oct_reset_hold");
    step(1'b0, 5'd14, 0, 4, "t4_gap");

    // 5: legato keycode changes, ignored key, note-to-octave switch
    step(1'b1, 5'd0,  1,  4, "t5_c");
    step(1'b1, 5'd11, 12, 4, "t5_b");
    step(1'b1, 5'd20, 0,  4, "t5_ignored");
    step(1'b1, 5'd15, 0,  4, "t5_ignored15");
    step(1'b1, 5'd11, 12, 4, "t5_b_again");
    step(1'b1, 5'd13, 0,  5, "t5_legato_up");
    step(1'b1, 5'd13, 0,  5, "t5_legato_hold");
    step(1'b0, 5'd0,  0,  5, "t5_rel");

    // 6: asynchronous reset mid-note, release with octave-up held
    step(1'b1, 5'd13, 0, 6, "t6_up");
    step(1'b0, 5'd13, 0, 6, "t6_gap");
    step(1'b1, 5'd3,  4, 6, "t6_note");
    @(negedge clk);
    rst_n      = 1'b0;
    kp.ready   = 1'b1;
    kp.keycode = 5'd13;
    #1;
    check_now(0, 4, "t6_async_rst");
    @(posedge clk);
    #1;
    check_now(0, 4, "t6_rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 5'd13, 0, 5, "t6_repress");
    step(1'b1, 5'd13, 0, 5, "t6_hold");
    step(1'b1, 5'd2,  3, 5, "t6_note_after");
    step(1'b0, 5'd2,  0, 5, "t6_rel");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

`default_nettype wire
